// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. 16x oversampling, mid-bit start validation,
// 3-sample majority per bit, stop-bit check, valid/ready byte output with
// framing-error and overrun pulses.
module uart_rx #(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115200,
   parameter int OS     = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun
);

   localparam int DIV = CLK_HZ / (BAUD * OS);
   localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;

   generate
      if (OS != 16) begin : g_os_chk
         $error("uart_rx: OS must be 16");
      end
      if (DIV < 2) begin : g_div_chk
         $error("uart_rx: CLK_HZ/(BAUD*OS) must be at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_nxt;
   logic [1:0]      sync;
   logic            rx_s;
   logic [DW-1:0]   div_cnt;
   logic            tick;
   logic [3:0]      os_cnt;
   logic [2:0]      bit_cnt;
   logic [2:0]      samp;
   logic            s9, maj;
   logic [7:0]      shreg;
   logic            armed;
   logic            bit_done, stop_eval, good_done, bad_done, load, drop;

   assign rx_s = sync[1];
   assign tick = (div_cnt == DW'(DIV - 1));

   // The third sample is still being taken when STOP is judged at os_cnt=9,
   // so use the live line value there instead of the stored one.
   assign s9  = (os_cnt == 4'd9) ? rx_s : samp[2];
   assign maj = (samp[0] & samp[1]) | (samp[0] & s9) | (samp[1] & s9);

   // Two-flop synchroniser for the asynchronous line; idles high.
   always_ff @(posedge clk) begin
      if (rst) sync <= 2'b11;
      else     sync <= {sync[0], rx};
   end

   // Free-running oversample tick divider.
   always_ff @(posedge clk) begin
      if (rst)       div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + DW'(1);
   end

   // State register; busy is registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
      end
   end

   // Next-state logic; all transitions happen on oversample ticks.
   always_comb begin
      state_nxt = state;
      if (tick) begin
         case (state)
            IDLE:    if (armed && !rx_s) state_nxt = START;
            START:   if (os_cnt == 4'd7 && rx_s) state_nxt = IDLE;
                     else if (os_cnt == 4'd15)   state_nxt = DATA;
            DATA:    if (os_cnt == 4'd15 && bit_cnt == 3'd7) state_nxt = STOP;
            STOP:    if (os_cnt == 4'd9) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Control strobes derived from state, counters and the handshake.
   always_comb begin
      bit_done  = tick && (state == DATA) && (os_cnt == 4'd15);
      stop_eval = tick && (state == STOP) && (os_cnt == 4'd9);
      good_done = stop_eval && maj;
      bad_done  = stop_eval && !maj;
      load      = good_done && (!rx_valid || rx_ready);
      drop      = good_done && rx_valid && !rx_ready;
   end

   // Frame datapath: oversample/bit counters, majority samples, shifter, arm.
   always_ff @(posedge clk) begin
      if (rst) begin
         os_cnt  <= 4'd0;
         bit_cnt <= 3'd0;
         samp    <= 3'b000;
         shreg   <= 8'h00;
         armed   <= 1'b1;
      end else begin
         if (state_nxt != state)          os_cnt <= 4'd0;
         else if (tick && state != IDLE)  os_cnt <= os_cnt + 4'd1;

         if (tick) begin
            case (os_cnt)
               4'd7:    samp[0] <= rx_s;
               4'd8:    samp[1] <= rx_s;
               4'd9:    samp[2] <= rx_s;
               default: ;
            endcase
         end

         if (state == START && state_nxt == DATA) bit_cnt <= 3'd0;
         else if (bit_done)                       bit_cnt <= bit_cnt + 3'd1;

         if (bit_done) shreg <= {maj, shreg[7:1]};

         // A bad stop bit disarms start detection until the line goes high,
         // so a break is not seen as a stream of frames.
         if (tick && state == IDLE && rx_s) armed <= 1'b1;
         else if (bad_done)                 armed <= 1'b0;
      end
   end

   // Output holding register and one-cycle error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= bad_done;
         overrun   <= drop;
         if (load) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx; expected bytes are queued at send
// time and a separate monitor pops and compares on every transfer.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, busy, frame_err, overrun;

   // 32 MHz / 1 Mbaud / 16 gives a divider of 2 and 32 clk per bit.
   localparam int BIT_CLK = 32;
   localparam int LAT_MAX = 2 + 16 * 19 + 4;   // 2 + 16*9.5*2 + 4

   typedef struct {
      logic [7:0] d;
      int         c0;
      bit         chk_lat;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0, base = 0;
   int   checks = 0, errors = 0;
   int   fe_cnt = 0, ov_cnt = 0, busy_cnt = 0;
   int   b0, f0, o0;

   uart_rx #(.CLK_HZ(32_000_000), .BAUD(1_000_000), .OS(16)) dut (
      .clk(clk), .rst(rst), .rx(rx), .rx_ready(rx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .frame_err(frame_err), .overrun(overrun)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Drive nbits of an 8N1 frame, bit period L clk. The start edge is placed
   // so the synchronised low meets an oversample tick two clocks later.
   task automatic send(input logic [7:0] d, input int L, input logic stop_v,
                       input bit spike, input int nbits, input bit push, input bit do_lat);
      logic [9:0] fr;
      fr = {stop_v, d, 1'b0};
      if (((cyc - base) & 1) == 0) @(negedge clk);
      if (push) exp_q.push_back('{d, cyc + 1, do_lat});
      for (int i = 0; i < nbits; i++) begin
         for (int c = 0; c < L; c++) begin
            rx = (spike && i == 4 && c == L / 2) ? ~fr[i] : fr[i];
            @(negedge clk);
         end
      end
   endtask

   // Monitor: pops the scoreboard on each transfer, checks hold-while-valid,
   // and counts the pulse outputs.
   initial begin
      logic       pv, pr, prst;
      logic [7:0] pd;
      exp_t       e;
      int         lat;
      pv = 1'b0; pr = 1'b0; prst = 1'b1; pd = 8'h00;
      forever begin
         @(negedge clk); #1;
         if (pv && !pr && !prst) begin
            chk("hold_valid", 32'(rx_valid), 32'd1);
            chk("hold_data", 32'(rx_data), 32'(pd));
         end
         if (rx_valid && rx_ready && !rst) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_byte: got %02h expected none", rx_data);
            end else begin
               e = exp_q.pop_front();
               chk("rx_data", 32'(rx_data), 32'(e.d));
               if (e.chk_lat) begin
                  lat = cyc - e.c0;
                  checks++;
                  if (lat > LAT_MAX) begin
                     errors++;
                     $display("FAIL latency: got %0d clk expected <= %0d", lat, LAT_MAX);
                  end
               end
            end
         end
         if (frame_err) fe_cnt++;
         if (overrun)   ov_cnt++;
         if (busy)      busy_cnt++;
         pv = rx_valid; pr = rx_ready; prst = rst; pd = rx_data;
      end
   end

   initial begin
      repeat (4) @(negedge clk);
      chk("rst_valid", 32'(rx_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_data", 32'(rx_data), 32'd0);
      rst = 1'b0; base = cyc;

      // idle line
      repeat (500) @(negedge clk);
      chk("idle_busy", busy_cnt, 0);
      chk("idle_frame_err", fe_cnt, 0);
      chk("idle_overrun", ov_cnt, 0);
      chk("idle_valid", 32'(rx_valid), 32'd0);

      // back-to-back frames
      send(8'h55, BIT_CLK, 1'b1, 1'b0, 10, 1'b1, 1'b1);
      send(8'hA5, BIT_CLK, 1'b1, 1'b0, 10, 1'b1, 1'b1);
      send(8'h00, BIT_CLK, 1'b1, 1'b0, 10, 1'b1, 1'b1);
      send(8'hFF, BIT_CLK, 1'b1, 1'b0, 10, 1'b1, 1'b1);
      repeat (40) @(negedge clk);
      chk("b2b_all_received", exp_q.size(), 0);

      // reset in the middle of 0xA5
      send(8'hA5, BIT_CLK, 1'b1, 1'b0, 5, 1'b0, 1'b0);
      chk("mid_frame_busy", 32'(busy), 32'd1);
      rst = 1'b1; rx = 1'b1;
      @(negedge clk);
      chk("mid_rst_data", 32'(rx_data), 32'd0);
      chk("mid_rst_valid", 32'(rx_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_frame_err", 32'(frame_err), 32'd0);
      chk("mid_rst_overrun", 32'(overrun), 32'd0);
      rst = 1'b0; base = cyc; b0 = busy_cnt;
      repeat (400) @(negedge clk);
      chk("post_rst_idle_busy", busy_cnt - b0, 0);

      // 4-clk glitch
      b0 = busy_cnt; f0 = fe_cnt;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (60) @(negedge clk);
      checks++;
      if (busy_cnt == b0) begin
         errors++;
         $display("FAIL glitch_busy_pulse: got 0 busy cycles expected > 0");
      end
      chk("glitch_busy_end", 32'(busy), 32'd0);
      chk("glitch_frame_err", fe_cnt - f0, 0);

      // bad stop bit, break, then a good frame
      f0 = fe_cnt;
      send(8'h3C, BIT_CLK, 1'b0, 1'b0, 10, 1'b0, 1'b0);
      b0 = busy_cnt;
      rx = 1'b0;
      repeat (400) @(negedge clk);
      chk("break_no_retrigger", busy_cnt - b0, 0);
      chk("frame_err_pulses", fe_cnt - f0, 1);
      rx = 1'b1;
      repeat (64) @(negedge clk);
      send(8'h81, BIT_CLK, 1'b1, 1'b0, 10, 1'b1, 1'b1);
      repeat (40) @(negedge clk);
      chk("after_break_received", exp_q.size(), 0);

      // overrun with consumer stalled
      rx_ready = 1'b0; o0 = ov_cnt;
      send(8'h11, BIT_CLK, 1'b1, 1'b0, 10, 1'b1, 1'b0);
      send(8'h22, BIT_CLK, 1'b1, 1'b0, 10, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      chk("overrun_pulses", ov_cnt - o0, 1);
      chk("overrun_data_kept", 32'(rx_data), 32'h11);
      chk("overrun_valid_held", 32'(rx_valid), 32'd1);
      rx_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("overrun_drained_valid", 32'(rx_valid), 32'd0);

      // baud skew with a one-clk spike in data bit 3
      send(8'hC3, 31, 1'b1, 1'b1, 10, 1'b1, 1'b0);
      send(8'hC3, 33, 1'b1, 1'b1, 10, 1'b1, 1'b0);
      repeat (60) @(negedge clk);
      chk("skew_all_received", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
